dual_note_tone_synth: RTL and testbench

Dual-voice audio sample generator that consumes the 3-bit bass/high note codes, mixer flag, voice select and waveform select produced by the song sequencer or manual switches. It runs two 32-bit phase accumulators at a fixed sample rate and renders square or triangle waves. It delivers signed 32-bit samples to the audio codec write path through a valid/ready handshake.

---
 rtl/dual_note_tone_synth.sv | 158 +++++++++++++++
 tb/tb_dual_note_tone_synth.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/dual_note_tone_synth.sv
// Two-voice square/triangle tone generator: 32-bit phase accumulators stepped once per
// sample tick, sample presented to the codec path through a valid/ready handshake.
module dual_note_tone_synth #(
    parameter int CLK_DIV = 1042,
    parameter int AMP     = 134217728
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         switches1,
    input  logic [2:0]         switches2,
    input  logic               mode,
    input  logic               mixer,
    input  logic               switch,
    input  logic               audio_ready,
    output logic signed [31:0] tone,
    output logic               readValid,
    output logic               overrun
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic signed [31:0] AMP_S = 32'(AMP);

    typedef enum logic [1:0] {S_WAIT, S_UPDATE, S_GEN, S_VALID} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q;
    logic [31:0]        ph_b_q, ph_b_d, ph_h_q, ph_h_d;
    logic [2:0]         code_b_q, code_b_d, code_h_q, code_h_d;
    logic               mode_q, mode_d, mixer_q, mixer_d, wave_q, wave_d;
    logic signed [31:0] tone_q, tone_d;
    logic               vld_q, vld_d, ovr_q, ovr_d;
    logic               tick;
    logic signed [31:0] v_b, v_h, sample;
    logic signed [32:0] sum;

    // round(f * 2^32 / 48000) for octave 2/3; high voice is the same notes two octaves up
    function automatic logic [31:0] bass_inc(input logic [2:0] c);
        case (c)
            3'd1:    return 32'd6569510;
            3'd2:    return 32'd7373922;
            3'd3:    return 32'd7812367;
            3'd4:    return 32'd8768892;
            3'd5:    return 32'd9842633;
            3'd6:    return 32'd11047909;
            3'd7:    return 32'd11704681;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] high_inc(input logic [2:0] c);
        case (c)
            3'd1:    return 32'd26278042;
            3'd2:    return 32'd29495688;
            3'd3:    return 32'd31249466;
            3'd4:    return 32'd35075566;
            3'd5:    return 32'd39370534;
            3'd6:    return 32'd44191634;
            3'd7:    return 32'd46818723;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic signed [31:0] voice_val(input logic [2:0] c, input logic [31:0] ph,
                                                     input logic tri_w);
        logic [30:0]        t;
        logic signed [31:0] d;
        t = ph[31] ? ~ph[30:0] : ph[30:0];
        d = $signed({1'b0, t}) - 32'sd1073741824;
        if (c == 3'd0)  return 32'sd0;
        if (!tri_w)     return ph[31] ? -AMP_S : AMP_S;
        return d >>> 3;
    endfunction

    assign tick = (cnt_q == CW'(CLK_DIV - 1));

    assign v_b    = voice_val(code_b_q, ph_b_q, wave_q);
    assign v_h    = voice_val(code_h_q, ph_h_q, wave_q);
    assign sum    = {v_b[31], v_b} + {v_h[31], v_h};
    assign sample = mixer_q ? sum[32:1] : (mode_q ? v_h : v_b);

    always_comb begin
        state_d  = state_q;
        ph_b_d   = ph_b_q;
        ph_h_d   = ph_h_q;
        code_b_d = code_b_q;
        code_h_d = code_h_q;
        mode_d   = mode_q;
        mixer_d  = mixer_q;
        wave_d   = wave_q;
        tone_d   = tone_q;
        vld_d    = vld_q;
        ovr_d    = ovr_q;
        case (state_q)
            S_WAIT: if (tick) state_d = S_UPDATE;
            S_UPDATE: begin
                // a new note restarts its phase so every note begins at the same waveform point
                ph_b_d   = (switches1 != code_b_q || switches1 == 3'd0) ? 32'd0
                                                                        : ph_b_q + bass_inc(switches1);
                ph_h_d   = (switches2 != code_h_q || switches2 == 3'd0) ? 32'd0
                                                                        : ph_h_q + high_inc(switches2);
                code_b_d = switches1;
                code_h_d = switches2;
                mode_d   = mode;
                mixer_d  = mixer;
                wave_d   = switch;
                state_d  = S_GEN;
            end
            S_GEN: begin
                tone_d  = sample;
                vld_d   = 1'b1;
                state_d = S_VALID;
            end
            S_VALID: begin
                if (audio_ready) begin
                    vld_d   = 1'b0;
                    state_d = tick ? S_UPDATE : S_WAIT;
                end else if (tick) begin
                    ovr_d   = 1'b1;
                    state_d = S_UPDATE;
                end
            end
            default: state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_WAIT;
            cnt_q    <= '0;
            ph_b_q   <= '0;
            ph_h_q   <= '0;
            code_b_q <= '0;
            code_h_q <= '0;
            mode_q   <= 1'b0;
            mixer_q  <= 1'b0;
            wave_q   <= 1'b0;
            tone_q   <= '0;
            vld_q    <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            cnt_q    <= tick ? '0 : cnt_q + 1'b1;
            state_q  <= state_d;
            ph_b_q   <= ph_b_d;
            ph_h_q   <= ph_h_d;
            code_b_q <= code_b_d;
            code_h_q <= code_h_d;
            mode_q   <= mode_d;
            mixer_q  <= mixer_d;
            wave_q   <= wave_d;
            tone_q   <= tone_d;
            vld_q    <= vld_d;
            ovr_q    <= ovr_d;
        end
    end

    assign tone      = tone_q;
    assign readValid = vld_q;
    assign overrun   = ovr_q;
endmodule

// File: tb/tb_dual_note_tone_synth.sv
// Directed + random bench for dual_note_tone_synth against a frequency-table phase model.
module tb_dual_note_tone_synth;
    localparam longint P31  = 64'd2147483648;
    localparam longint P32  = 64'd4294967296;
    localparam longint AMPL = 64'd134217728;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [2:0]         switches1 = 3'd0, switches2 = 3'd0;
    logic               mode = 1'b0, mixer = 1'b1, switch = 1'b0, audio_ready = 1'b1;
    logic signed [31:0] tone;
    logic               readValid, overrun;

    int total = 0;
    int bad   = 0;

    real    fq [8] = '{0.0, 73.42, 82.41, 87.31, 98.0, 110.0, 123.47, 130.81};
    longint mph_b, mph_h, exp_tone, prev_tone;
    logic [2:0] mprev_b, mprev_h;
    bit     movr;

    dual_note_tone_synth dut (
        .clk(clk), .rst(rst), .switches1(switches1), .switches2(switches2),
        .mode(mode), .mixer(mixer), .switch(switch), .audio_ready(audio_ready),
        .tone(tone), .readValid(readValid), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint inc_of(input real f);
        return longint'($rtoi(f * 4294967296.0 / 48000.0 + 0.5));
    endfunction

    function automatic longint floordiv(input longint x, input longint d);
        longint q = x / d;
        if ((x % d) != 0 && x < 0) q = q - 1;
        return q;
    endfunction

    function automatic longint vval(input logic [2:0] c, input longint ph, input bit tri_w);
        longint t;
        if (c == 3'd0) return 0;
        if (!tri_w) return (ph < P31) ? AMPL : -AMPL;
        t = (ph < P31) ? ph : (P32 - 1 - ph);
        return floordiv(t - 64'd1073741824, 8);
    endfunction

    task automatic check_sample(input string tag);
        longint vb, vh;
        mph_b = (switches1 != mprev_b || switches1 == 0) ? 0 : (mph_b + inc_of(fq[switches1])) % P32;
        mph_h = (switches2 != mprev_h || switches2 == 0) ? 0 : (mph_h + inc_of(4.0 * fq[switches2])) % P32;
        mprev_b = switches1;
        mprev_h = switches2;
        vb = vval(switches1, mph_b, switch);
        vh = vval(switches2, mph_h, switch);
        prev_tone = exp_tone;
        exp_tone  = mixer ? floordiv(vb + vh, 2) : (mode ? vh : vb);
        chk({tag, "_tone"}, tone, exp_tone);
        chk({tag, "_vld"}, readValid, 1);
        chk({tag, "_ovr"}, overrun, movr);
    endtask

    // One sample period: transfer edge, then wait until the next sample is registered.
    task automatic advance(input bit rdy);
        audio_ready = rdy;
        @(posedge clk); #1;
        chk("vld_after", readValid, rdy ? 1'b0 : 1'b1);
        chk("tone_hold", tone, exp_tone);
        if (!rdy) movr = 1'b1;
        repeat (1041) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        #3;
        chk({tag, "_rst_tone"}, tone, 0);
        chk({tag, "_rst_vld"}, readValid, 0);
        chk({tag, "_rst_ovr"}, overrun, 0);
        repeat (3) @(posedge clk);
        mph_b = 0; mph_h = 0; mprev_b = 0; mprev_h = 0; movr = 0; exp_tone = 0;
        @(negedge clk) rst = 1'b1;
        repeat (1043) @(posedge clk);
        #1;
        chk({tag, "_vld_early"}, readValid, 0);
        @(posedge clk); #1;
        check_sample({tag, "_first"});
    endtask

    initial begin
        do_reset("por");
        for (int i = 0; i < 2; i++) begin advance(1); check_sample("silence"); end

        switches1 = 3'd5; mixer = 1'b0; mode = 1'b0; switch = 1'b0;
        advance(1); check_sample("bassA_sq");
        chk("bassA_first", tone, AMPL);
        for (int i = 0; i < 3; i++) begin advance(1); check_sample("bassA_sq"); end

        switches2 = 3'd5; mixer = 1'b1;
        for (int i = 0; i < 3; i++) begin advance(1); check_sample("mixA_sq"); end

        switch = 1'b1; mixer = 1'b0; mode = 1'b1; switches2 = 3'd7;
        advance(1); check_sample("highC_tri");
        chk("tri_first", tone, -AMPL);
        for (int i = 0; i < 3; i++) begin
            advance(1); check_sample("highC_tri");
            chk("tri_rising", longint'(tone) > prev_tone, 1);
        end

        advance(0); check_sample("overrun");
        advance(1); check_sample("overrun_sticky");

        for (int i = 0; i < 30; i++) begin
            switches1 = 3'($urandom_range(0, 7));
            switches2 = 3'($urandom_range(0, 7));
            mode   = 1'($urandom);
            mixer  = 1'($urandom);
            switch = 1'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                // hold codes so phases keep accumulating
                switches1 = mprev_b; switches2 = mprev_h;
            end
            advance($urandom_range(0, 3) != 0);
            check_sample("rand");
        end

        audio_ready = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_vld", readValid, 0);
        do_reset("midrst");
        for (int i = 0; i < 3; i++) begin
            switches1 = 3'($urandom_range(1, 7));
            switches2 = 3'($urandom_range(1, 7));
            mixer = 1'b1; switch = 1'($urandom);
            advance(1); check_sample("post_rst");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
